// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: synchronises the rx_done level, turns each
// rising edge into one write strobe and queues bytes in a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overrun,
    input  logic          clr_ovr
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic          s1, s2, s3;
    logic          warm1, warm2, armed;
    logic          wr_stb, pop, wr_en, drop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          overrun_q;
    logic [7:0]    mem [DEPTH];

    // armed only after s2 has shown a genuine low sample since reset, so a rx_done
    // level still high across reset release cannot masquerade as a fresh byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            warm1 <= 1'b0;
            warm2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= rx_done;
            s2    <= s1;
            s3    <= s2;
            warm1 <= 1'b1;
            warm2 <= warm1;
            if (warm2 && !s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign wr_stb = s2 & ~s3 & armed;
    assign pop    = rd_valid & rd_ready;
    assign wr_en  = wr_stb & (~full | pop);
    assign drop   = wr_stb & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign rd_valid = ~empty;
    assign overrun  = overrun_q;
    // Memory is not reset, so the head is masked while empty to give a defined 00.
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model plus
// table-driven vectors and directed corner-case sequences.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overrun;
    logic          clr_ovr;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: byte queue, sticky overrun, rx_done edge tracking.
    logic [7:0] mq[$];
    logic [7:0] out_q[$];
    bit         movr;
    int         hi_run;
    bit         m_armed;
    bit         rnd_rdy;

    typedef struct {
        logic [7:0] data;
        bit         rdy;
        int         exp_count;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        movr    = 1'b0;
        hi_run  = 0;
        m_armed = 1'b0;
    endtask

    // One clock: update model from the pre-edge inputs, advance, compare.
    task automatic tick();
        bit m_pop, m_wr, accept;
        if (rnd_rdy) rd_ready = 1'($urandom_range(0, 1));
        m_pop = (mq.size() > 0) && rd_ready;
        if (rd_valid && rd_ready) out_q.push_back(rd_data);
        m_wr = 1'b0;
        if (rx_done) begin
            hi_run++;
            if (hi_run == 3 && m_armed) m_wr = 1'b1;
        end else begin
            hi_run  = 0;
            m_armed = 1'b1;
        end
        accept = m_wr && ((mq.size() < DEPTH) || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (accept) mq.push_back(rx_data);
        if (m_wr && !accept) movr = 1'b1;
        else if (clr_ovr) movr = 1'b0;
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        check("overrun", 32'(overrun), 32'(movr));
        if (mq.size() > 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hi) tick();
        rx_done = 1'b0;
        repeat (lo) tick();
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h11, 1'b0, 1};
        vecs[1] = '{8'h22, 1'b0, 2};
        vecs[2] = '{8'h33, 1'b0, 3};
        vecs[3] = '{8'h44, 1'b1, 0};
        vecs[4] = '{8'h55, 1'b0, 1};
        vecs[5] = '{8'h66, 1'b0, 2};
        vecs[6] = '{8'h77, 1'b1, 0};

        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        clr_ovr  = 1'b0;
        rnd_rdy  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset and idle
        repeat (20) tick();
        check("idle_rd_data", 32'(rd_data), 32'h00);
        check("idle_count", 32'(count), 0);

        // Single byte latency, one write despite a long high level
        rx_data = 8'hA5;
        rx_done = 1'b1;
        tick();
        tick();
        check("lat_not_yet", 32'(rd_valid), 0);
        tick();
        check("lat_valid", 32'(rd_valid), 1);
        check("lat_data", 32'(rd_data), 32'hA5);
        repeat (13) tick();
        rx_done = 1'b0;
        repeat (3) tick();
        check("lat_one_write", 32'(count), 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("lat_drained", 32'(empty), 1);

        // Table-driven vectors: byte, rd_ready during the send, occupancy afterwards
        foreach (vecs[i]) begin
            rd_ready = vecs[i].rdy;
            send_byte(vecs[i].data, 4, 3);
            check("vec_count", 32'(count), 32'(vecs[i].exp_count));
        end
        rd_ready = 1'b0;

        // Fill and overrun
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 4, 3);
            if (i == 15) check("fill_full", 32'(full), 1);
        end
        check("ovr_set", 32'(overrun), 1);
        check("ovr_count", 32'(count), 16);
        out_q.delete();
        rd_ready = 1'b1;
        repeat (17) tick();
        rd_ready = 1'b0;
        check("drain_len", 32'(out_q.size()), 16);
        for (int i = 0; i < out_q.size(); i++) check("drain_order", 32'(out_q[i]), 32'(i));
        check("ovr_kept", 32'(overrun), 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_clr", 32'(overrun), 0);

        // Simultaneous pop at full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 4, 3);
        check("pf_full", 32'(full), 1);
        rx_data = 8'h3C;
        rx_done = 1'b1;
        tick();
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pf_count", 32'(count), 16);
        check("pf_no_ovr", 32'(overrun), 0);
        rx_done = 1'b0;
        repeat (3) tick();
        out_q.delete();
        rd_ready = 1'b1;
        repeat (17) tick();
        rd_ready = 1'b0;
        check("pf_len", 32'(out_q.size()), 16);
        if (out_q.size() == 16) begin
            check("pf_first", 32'(out_q[0]), 32'h21);
            check("pf_last", 32'(out_q[15]), 32'h3C);
        end

        // Wrap-around streaming with random stalls
        out_q.delete();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(8'h80 + i), 3 + int'($urandom_range(0, 3)), 2 + int'($urandom_range(0, 3)));
            if (count == 5'(DEPTH)) check("stream_not_full", 32'(count), 32'(DEPTH - 1));
        end
        rnd_rdy  = 1'b0;
        rd_ready = 1'b1;
        repeat (20) tick();
        rd_ready = 1'b0;
        check("stream_len", 32'(out_q.size()), 40);
        for (int i = 0; i < out_q.size(); i++) check("stream_order", 32'(out_q[i]), 32'(8'h80 + i));
        check("stream_empty", 32'(empty), 1);
        check("stream_count", 32'(count), 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 4, 3);
        check("ar_stored", 32'(count), 5);
        rx_data = 8'hEE;
        rx_done = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("ar_count", 32'(count), 0);
        check("ar_empty", 32'(empty), 1);
        check("ar_valid", 32'(rd_valid), 0);
        check("ar_full", 32'(full), 0);
        check("ar_ovr", 32'(overrun), 0);
        check("ar_data", 32'(rd_data), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) tick();
        check("ar_no_write", 32'(count), 0);
        rx_done = 1'b0;
        repeat (3) tick();
        send_byte(8'h5A, 5, 3);
        check("ar_rewrite", 32'(count), 1);
        check("ar_rewrite_data", 32'(rd_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Detects each completed byte on the receiver's rx_done level and stores the byte in a first-word-fall-through FIFO.
- Presents bytes to the consumer over a valid/ready handshake, with occupancy, full/empty and sticky overrun status.
- Decouples the baud-tick-paced receiver from a consumer that may stall for many byte times.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- AW, 4, address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver; stable for the whole time rx_done is high.
- rx_done  input  1  receiver byte-complete level; high for roughly one stop-bit period per byte; not synchronous to clk.
- rd_data  output  8  head-of-FIFO byte; valid only while rd_valid=1.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  consumer accepts; a pop occurs on any edge where rd_valid=1 and rd_ready=1.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overrun  output  1  sticky; set when a byte is dropped because the FIFO is full.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overrun=0, synchroniser flops=0, rd_data=8'h00. Memory contents are not reset. Reset mid-byte discards all stored data.
- Input synchroniser: rx_done passes through two flops (s1, s2) plus a delay flop s3. The write strobe is wr_stb = s2 & ~s3, exactly one clk cycle per rx_done rising edge.
- rx_data is sampled directly at wr_stb. This is safe because rx_done has been high for at least 2 clk cycles, so rx_data is stable.
- Latency: wr_stb is high in the cycle after the 2nd edge that samples rx_done high. The write occurs on the 3rd such edge, and rd_valid rises after it.
- A rx_done pulse shorter than 2 clk cycles may be missed. This is not supported.
- Holding rx_done high produces no further writes. A fresh write needs rx_done low for at least 2 clk cycles, then high again.
- Write (wr_stb=1, not full): mem[wr_ptr]<=rx_data; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- Read (rd_valid & rd_ready): rd_ptr<=rd_ptr+1, wrapping modulo DEPTH.
- rd_data: combinational mem[rd_ptr] (first-word fall-through); the new head appears in the cycle after a pop. rd_ready while empty has no effect.
- count:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop, or when neither occurs.
- full/empty/rd_valid: decoded from registered count (rd_valid = ~empty).
- Full boundary:
  - wr_stb while full with no pop in the same cycle: byte dropped, pointers and count unchanged, overrun<=1 on that edge.
  - wr_stb while full with a simultaneous pop: write accepted, count stays DEPTH, no overrun.
- Empty boundary: wr_stb while empty writes; rd_valid rises the next cycle. No same-cycle bypass.
- overrun:
  - Sets on a dropped byte.
  - Clears when clr_ovr=1.
  - If set and clear occur in the same cycle, set wins.
  - Has no effect on FIFO contents.
- Pointer wrap is transparent: the order of bytes is preserved across the DEPTH boundary.

Test Plan:
- Reset and idle: rst=0 then 1, rx_done=0 for 20 cycles -> count=0, empty=1, rd_valid=0, overrun=0, rd_data=8'h00.
- Single byte latency: rx_data=8'hA5, rx_done high for 16 cycles, rd_ready=0 -> rd_valid rises after the 3rd edge sampling rx_done high, rd_data=8'hA5, count=1. Exactly one write occurs despite the 16-cycle high.
- Fill and overrun: write 17 bytes 8'h00..8'h10 with rd_ready=0, DEPTH=16 -> full=1 after byte 16, byte 8'h10 dropped, overrun=1, count=16. Draining then returns 8'h00..8'h0F in order. Pulse clr_ovr -> overrun=0.
- Simultaneous pop at full: FIFO full, rd_ready=1 in the wr_stb cycle, rx_data=8'h3C -> count stays 16, overrun stays 0, 8'h3C is the last byte drained.
- Wrap-around streaming: 40 bytes (incrementing from 8'h80) with random rd_ready stalls and count never reaching 16 -> output sequence identical to input, count returns to 0, empty=1.
- Asynchronous reset mid-operation: 5 bytes stored, rx_done high, assert rst=0 between clk edges -> all outputs return to reset values immediately. After release, rx_done still high produces no write until it goes low for at least 2 cycles and rises again.
